// File: rtl/pz_pkg.sv
// Shared push-button/zombie game definitions: button count, id width and
// the button index enum used by the conditioner and the hit detector.
package pz_pkg;

  localparam int unsigned N_BTN    = 3;
  localparam int unsigned BTN_ID_W = 2;

  typedef enum logic [BTN_ID_W-1:0] {
    BTN1 = 2'd0,
    BTN2 = 2'd1,
    BTN3 = 2'd2
  } btn_id_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: polarity correction, synchroniser, consecutive-sample
// debounce counter, debounced level and en-gated press/release pulses.
module btn_debounce_ch #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic press_evt
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   p;
  logic                   s;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  assign p = btn_raw ^ ACTIVE_LOW;
  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], p};
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Level and pulse are committed on the same edge; en only masks the pulse.
      level_d   = s;
      cnt_d     = '0;
      press_d   = en & s;
      release_d = en & ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  // Pre-register press so the arbiter can register on the same edge.
  assign press_evt   = press_d;

endmodule

// File: rtl/btn_conditioner.sv
// Three-channel button conditioner: per-channel debounce instances plus a
// registered press arbiter (valid, lowest index, simultaneous flag).
module btn_conditioner #(
  parameter int unsigned N_BTN           = pz_pkg::N_BTN,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BTN-1:0]             btn_raw,
  input  logic                         en,
  output logic [N_BTN-1:0]             btn_level,
  output logic [N_BTN-1:0]             btn_press,
  output logic [N_BTN-1:0]             btn_release,
  output logic                         press_valid,
  output logic [pz_pkg::BTN_ID_W-1:0]  press_id,
  output logic                         multi_press
);

  import pz_pkg::*;

  logic [N_BTN-1:0]    press_evt;
  logic                press_valid_q, press_valid_d;
  logic [BTN_ID_W-1:0] press_id_q, press_id_d;
  logic                multi_press_q, multi_press_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw[g]),
      .en          (en),
      .btn_level   (btn_level[g]),
      .btn_press   (btn_press[g]),
      .btn_release (btn_release[g]),
      .press_evt   (press_evt[g])
    );
  end

  always_comb begin
    logic found;
    found         = 1'b0;
    press_valid_d = |press_evt;
    press_id_d    = '0;
    multi_press_d = ($countones(press_evt) > 1);
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (press_evt[i] && !found) begin
        press_id_d = BTN_ID_W'(i);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press_valid_q <= 1'b0;
      press_id_q    <= '0;
      multi_press_q <= 1'b0;
    end else begin
      press_valid_q <= press_valid_d;
      press_id_q    <= press_id_d;
      multi_press_q <= multi_press_d;
    end
  end

  assign press_valid = press_valid_q;
  assign press_id    = press_id_q;
  assign multi_press = multi_press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected pulse words are queued when
// stimulus is driven and compared every cycle against both DUT instances.
module tb_btn_conditioner;

  localparam int unsigned LAT = 6; // SYNC_STAGES + DEBOUNCE_CYCLES

  typedef struct {
    int unsigned cyc;
    logic [9:0]  val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] raw0, raw1;

  logic [2:0] lvl0, prs0, rel0, lvl1, prs1, rel1;
  logic       pv0, mp0, pv1, mp1;
  logic [1:0] pid0, pid1;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_conditioner #(
    .N_BTN(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(raw0), .en(en),
    .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0),
    .press_valid(pv0), .press_id(pid0), .multi_press(mp0)
  );

  btn_conditioner #(
    .N_BTN(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst(rst), .btn_raw(raw1), .en(en),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1),
    .press_valid(pv1), .press_id(pid1), .multi_press(mp1)
  );

  function automatic logic [9:0] mk(input logic [2:0] prs, input logic [2:0] rel,
                                    input logic pv, input logic [1:0] pid,
                                    input logic mp);
    return {prs, rel, pv, pid, mp};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push0(input int unsigned at, input logic [9:0] v);
    exp_t e;
    e.cyc = at;
    e.val = v;
    q0.push_back(e);
  endtask

  task automatic push1(input int unsigned at, input logic [9:0] v);
    exp_t e;
    e.cyc = at;
    e.val = v;
    q1.push_back(e);
  endtask

  // Pulse/arbiter outputs must be zero except in cycles the scoreboard names.
  always @(negedge clk) begin
    logic [9:0] e0, e1;
    e0 = '0;
    e1 = '0;
    if (q0.size() != 0 && q0[0].cyc == cyc) e0 = q0.pop_front().val;
    if (q1.size() != 0 && q1[0].cyc == cyc) e1 = q1.pop_front().val;
    chk("dut_pulses", 32'(mk(prs0, rel0, pv0, pid0, mp0)), 32'(e0));
    chk("dut_al_pulses", 32'(mk(prs1, rel1, pv1, pid1, mp1)), 32'(e1));
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    raw0 = 3'b000;
    raw1 = 3'b111;
    step(2);
    chk("reset_level", 32'(lvl0), 32'h0);
    chk("reset_level_al", 32'(lvl1), 32'h0);
    rst = 1'b0;
    step(10);
    chk("al_idle_level", 32'(lvl1), 32'h0);

    // Clean press and release on btn0, with level boundary check
    raw0[0] = 1'b1;
    push0(cyc + LAT, mk(3'b001, 3'b000, 1'b1, 2'd0, 1'b0));
    step(LAT - 1);
    chk("press_level_before", 32'(lvl0), 32'h0);
    step(1);
    chk("press_level_after", 32'(lvl0), 32'h1);
    step(14);
    raw0[0] = 1'b0;
    push0(cyc + LAT, mk(3'b000, 3'b001, 1'b0, 2'd0, 1'b0));
    step(LAT - 1);
    chk("release_level_before", 32'(lvl0), 32'h1);
    step(1);
    chk("release_level_after", 32'(lvl0), 32'h0);
    step(4);

    // Bounce on btn1: 1,0,1,0,1 then hold
    raw0[1] = 1'b1; step(1);
    raw0[1] = 1'b0; step(1);
    raw0[1] = 1'b1; step(1);
    raw0[1] = 1'b0; step(1);
    raw0[1] = 1'b1;
    push0(cyc + LAT, mk(3'b010, 3'b000, 1'b1, 2'd1, 1'b0));
    step(12);
    chk("bounce_level", 32'(lvl0), 32'h2);
    raw0[1] = 1'b0;
    push0(cyc + LAT, mk(3'b000, 3'b010, 1'b0, 2'd0, 1'b0));
    step(10);

    // Glitch one cycle shorter than the debounce window on btn2
    raw0[2] = 1'b1;
    step(3);
    raw0[2] = 1'b0;
    step(3);
    chk("glitch_level", 32'(lvl0), 32'h0);
    step(8);
    chk("glitch_level_late", 32'(lvl0), 32'h0);

    // Simultaneous press on btn1+btn2, then btn0 while both held
    raw0 = 3'b110;
    push0(cyc + LAT, mk(3'b110, 3'b000, 1'b1, 2'd1, 1'b1));
    step(10);
    chk("simul_level", 32'(lvl0), 32'h6);
    raw0 = 3'b111;
    push0(cyc + LAT, mk(3'b001, 3'b000, 1'b1, 2'd0, 1'b0));
    step(10);
    raw0 = 3'b000;
    push0(cyc + LAT, mk(3'b000, 3'b111, 1'b0, 2'd0, 1'b0));
    step(10);
    chk("all_released", 32'(lvl0), 32'h0);

    // en gating, then reset with btn0 held
    en      = 1'b0;
    raw0[0] = 1'b1;
    step(LAT);
    chk("en0_level", 32'(lvl0), 32'h1);
    step(2);
    rst = 1'b1;
    step(1);
    chk("rst_level", 32'(lvl0), 32'h0);
    chk("rst_arb", 32'({pv0, pid0, mp0}), 32'h0);
    rst = 1'b0;
    en  = 1'b1;
    push0(cyc + LAT, mk(3'b001, 3'b000, 1'b1, 2'd0, 1'b0));
    step(LAT);
    chk("post_rst_level", 32'(lvl0), 32'h1);
    step(4);

    // Active-low instance: pin 0 driven low means pressed
    chk("al_held_level", 32'(lvl1), 32'h0);
    raw1[0] = 1'b0;
    push1(cyc + LAT, mk(3'b001, 3'b000, 1'b1, 2'd0, 1'b0));
    step(LAT);
    chk("al_press_level", 32'(lvl1), 32'h1);
    step(8);

    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
